// File: rtl/vsp_pkg.sv
// Shared firmware codes and sizing helper for the scalar pack unit and the blocks downstream of it.
package vsp_pkg;

   localparam logic [7:0] FW_PASS = 8'd0;
   localparam logic [7:0] FW_PACK = 8'd1;

   // Width of an element-count field able to hold 0..n
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/scalar_pack_lane.sv
// One chain's packing buffer: N scalar slots plus a fill counter.
// full_vec already contains the scalar being written this cycle, so the top
// can register a completed vector in the same cycle as its last element.
module scalar_pack_lane
   import vsp_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CW         = count_width(N)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  logic [DATA_WIDTH-1:0]            data,
   input  logic                             flush,
   input  logic                             clear,
   output logic [N-1:0][DATA_WIDTH-1:0]     full_vec,
   output logic [CW-1:0]                    fill_count
);

   logic [N-1:0][DATA_WIDTH-1:0] slots;

   // Buffer contents with the in-flight write merged into slot fill_count
   always_comb begin
      full_vec = slots;
      for (int i = 0; i < N; i++)
         if (wr_en && fill_count == CW'(i)) full_vec[i] = data;
   end

   // Slot/counter update; flush and clear both empty the buffer so stale
   // slots never leak into the zero padding of a later partial vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots      <= '0;
         fill_count <= '0;
      end else if (clear || flush) begin
         slots      <= '0;
         fill_count <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < N; i++)
            if (fill_count == CW'(i)) slots[i] <= data;
         fill_count <= fill_count + CW'(1);
      end
   end

endmodule

// File: rtl/vector_scalar_pack_unit.sv
// Re-densifies the zero-padded output of the scalar reduce stage: chains in
// PACK gather element 0 of successive vectors into N-wide vectors, chains in
// PASS forward vectors unchanged. Per-chain firmware is written in config mode.
module vector_scalar_pack_unit
   import vsp_pkg::*;
#(
   parameter int                      N                  = 8,
   parameter int                      DATA_WIDTH         = 32,
   parameter int                      MAX_CHAINS         = 4,
   parameter int                      PERSONAL_CONFIG_ID = 0,
   parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0,
   localparam int                     CW                 = count_width(N),
   localparam int                     CHW                = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic                         eof_in,
   input  logic [CHW-1:0]               chainId_in,
   input  logic                         tracing,
   input  logic [7:0]                   configId,
   input  logic [7:0]                   configData,
   input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
   output logic                         valid_out,
   output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
   output logic [CW-1:0]                count_out,
   output logic                         eof_out,
   output logic [CHW-1:0]               chainId_out
);

   logic [7:0]                                   firmware [MAX_CHAINS];
   logic [MAX_CHAINS-1:0]                        lane_wr, lane_flush, lane_clear;
   logic [MAX_CHAINS-1:0][N-1:0][DATA_WIDTH-1:0] lane_vec;
   logic [MAX_CHAINS-1:0][CW-1:0]                lane_cnt;

   int          cfg_off;
   logic        cfg_hit;
   logic        is_pack;
   logic [CW-1:0] k;
   logic        emit;

   // Config target decode and current-chain pack decision
   always_comb begin
      cfg_off = int'(configId) - PERSONAL_CONFIG_ID;
      cfg_hit = !tracing && (cfg_off >= 0) && (cfg_off < MAX_CHAINS);
      // reserved firmware values fall through to PASS
      is_pack = tracing && (firmware[chainId_in] == FW_PACK);
      k       = lane_cnt[chainId_in];
      if (valid_in) emit = (k == CW'(N - 1)) || eof_in;
      else          emit = eof_in && (k != '0);
   end

   // Firmware store, reloaded from INITIAL_FIRMWARE on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < MAX_CHAINS; c++) firmware[c] <= INITIAL_FIRMWARE[c*8 +: 8];
      end else if (cfg_hit) begin
         firmware[cfg_off[CHW-1:0]] <= configData;
      end
   end

   for (genvar c = 0; c < MAX_CHAINS; c++) begin : g_lane
      assign lane_wr[c]    = is_pack && valid_in && (chainId_in == CHW'(c));
      assign lane_flush[c] = is_pack && emit     && (chainId_in == CHW'(c));
      assign lane_clear[c] = cfg_hit && (cfg_off == c);

      scalar_pack_lane #(
         .N          (N),
         .DATA_WIDTH (DATA_WIDTH),
         .CW         (CW)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_en      (lane_wr[c]),
         .data       (vector_in[0]),
         .flush      (lane_flush[c]),
         .clear      (lane_clear[c]),
         .full_vec   (lane_vec[c]),
         .fill_count (lane_cnt[c])
      );
   end

   // Output register: config mode idles the outputs, trace mode selects PASS or PACK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out   <= 1'b0;
         vector_out  <= '0;
         count_out   <= '0;
         eof_out     <= 1'b0;
         chainId_out <= '0;
      end else if (!tracing) begin
         valid_out  <= 1'b0;
         vector_out <= '0;
         count_out  <= '0;
         eof_out    <= 1'b0;
      end else begin
         eof_out     <= eof_in;
         chainId_out <= chainId_in;
         if (is_pack) begin
            valid_out  <= emit;
            vector_out <= emit ? lane_vec[chainId_in] : '0;
            if (!emit)         count_out <= '0;
            else if (valid_in) count_out <= k + CW'(1);
            else               count_out <= k;
         end else begin
            valid_out  <= valid_in;
            vector_out <= vector_in;
            count_out  <= valid_in ? CW'(N) : '0;
         end
      end
   end

endmodule

// File: tb/tb_vector_scalar_pack_unit.sv
// Directed bench for vector_scalar_pack_unit (N=8, DATA_WIDTH=32, 4 chains).
module tb_vector_scalar_pack_unit;

   localparam int N  = 8;
   localparam int DW = 32;
   typedef logic [N-1:0][DW-1:0] vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_in, eof_in, tracing;
   logic [1:0] chainId_in;
   logic [7:0] configId, configData;
   vec_t       vector_in;
   logic       valid_out, eof_out;
   vec_t       vector_out;
   logic [3:0] count_out;
   logic [1:0] chainId_out;

   int n_chk  = 0;
   int n_fail = 0;

   vector_scalar_pack_unit #(
      .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0), .INITIAL_FIRMWARE(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in),
      .chainId_in(chainId_in), .tracing(tracing), .configId(configId),
      .configData(configData), .vector_in(vector_in), .valid_out(valid_out),
      .vector_out(vector_out), .count_out(count_out), .eof_out(eof_out),
      .chainId_out(chainId_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // element i = base + stride*i for i < cnt, zero above
   function automatic vec_t seq(input int base, input int stride, input int cnt);
      vec_t v = '0;
      for (int i = 0; i < cnt; i++) v[i] = DW'(base + stride * i);
      return v;
   endfunction

   // scalar in element 0, junk elsewhere (must be ignored in PACK)
   function automatic vec_t scal(input int v);
      vec_t r;
      for (int i = 0; i < N; i++) r[i] = 32'hDEAD_BEEF;
      r[0] = DW'(v);
      return r;
   endfunction

   // drive one trace-mode cycle, then sample 1 ns after the edge
   task automatic trace(input logic [1:0] ch, input logic v, input logic e, input vec_t d);
      tracing = 1'b1; chainId_in = ch; valid_in = v; eof_in = e; vector_in = d;
      @(posedge clk); #1;
   endtask

   task automatic cfg(input logic [7:0] id, input logic [7:0] data);
      tracing = 1'b0; configId = id; configData = data; valid_in = 1'b0; eof_in = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 0; eof_in = 0; tracing = 1; chainId_in = 0;
      configId = 8'hFF; configData = 0; vector_in = '0;
      #7;
      chk("rst_valid", 256'(valid_out), 256'(0));
      chk("rst_vec",   256'(vector_out), 256'(0));
      chk("rst_count", 256'(count_out), 256'(0));
      chk("rst_eof",   256'(eof_out), 256'(0));
      chk("rst_chain", 256'(chainId_out), 256'(0));
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // passthrough on chain 0
      trace(2'd0, 1, 0, seq(1, 1, 8));
      chk("pass_valid", 256'(valid_out), 256'(1));
      chk("pass_vec",   256'(vector_out), 256'(seq(1, 1, 8)));
      chk("pass_count", 256'(count_out), 256'(8));

      // chains 1 and 2 -> PACK
      cfg(8'd1, 8'd1);
      chk("cfg_valid", 256'(valid_out), 256'(0));
      cfg(8'd2, 8'd1);

      // full pack on chain 1
      for (int i = 0; i < 8; i++) begin
         trace(2'd1, 1, 0, scal(10 * (i + 1)));
         chk($sformatf("full_valid%0d", i), 256'(valid_out), 256'(i == 7));
      end
      chk("full_vec",   256'(vector_out), 256'(seq(10, 10, 8)));
      chk("full_count", 256'(count_out), 256'(8));
      chk("full_chain", 256'(chainId_out), 256'(1));
      trace(2'd1, 1, 0, scal(90));
      chk("ninth_valid", 256'(valid_out), 256'(0));
      // lone eof flushes the single element
      trace(2'd1, 0, 1, '0);
      chk("eof1_valid", 256'(valid_out), 256'(1));
      chk("eof1_vec",   256'(vector_out), 256'(seq(90, 0, 1)));
      chk("eof1_count", 256'(count_out), 256'(1));

      // partial flush with eof on the third input
      trace(2'd1, 1, 0, scal(5));
      trace(2'd1, 1, 0, scal(6));
      trace(2'd1, 1, 1, scal(7));
      chk("part_valid", 256'(valid_out), 256'(1));
      chk("part_vec",   256'(vector_out), 256'(seq(5, 1, 3)));
      chk("part_count", 256'(count_out), 256'(3));
      chk("part_eof",   256'(eof_out), 256'(1));
      trace(2'd1, 0, 1, '0);
      chk("empty_valid", 256'(valid_out), 256'(0));
      chk("empty_eof",   256'(eof_out), 256'(1));

      // interleave chains 1 (odd) and 2 (even)
      for (int v = 1; v <= 16; v++) begin
         trace((v % 2) ? 2'd1 : 2'd2, 1, 0, scal(v));
         chk($sformatf("il_valid%0d", v), 256'(valid_out), 256'(v >= 15));
         if (v == 15) begin
            chk("il_vec1",   256'(vector_out), 256'(seq(1, 2, 8)));
            chk("il_chain1", 256'(chainId_out), 256'(1));
         end
         if (v == 16) begin
            chk("il_vec2",   256'(vector_out), 256'(seq(2, 2, 8)));
            chk("il_chain2", 256'(chainId_out), 256'(2));
         end
      end

      // reconfigure chain 1 mid-fill; chain 2's partial must survive
      for (int i = 0; i < 3; i++) trace(2'd1, 1, 0, scal(100 + i));
      for (int i = 0; i < 3; i++) trace(2'd2, 1, 0, scal(200 + i));
      cfg(8'd1, 8'd0);
      trace(2'd1, 1, 0, seq(300, 7, 8));
      chk("recfg_valid", 256'(valid_out), 256'(1));
      chk("recfg_vec",   256'(vector_out), 256'(seq(300, 7, 8)));
      chk("recfg_count", 256'(count_out), 256'(8));
      trace(2'd2, 0, 1, '0);
      chk("keep_valid", 256'(valid_out), 256'(1));
      chk("keep_vec",   256'(vector_out), 256'(seq(200, 1, 3)));
      chk("keep_count", 256'(count_out), 256'(3));

      // async reset mid-fill on chain 2, with a live passthrough output
      trace(2'd2, 1, 0, scal(7));
      trace(2'd2, 1, 0, scal(8));
      trace(2'd0, 1, 0, seq(1, 1, 8));
      chk("pre_rst_valid", 256'(valid_out), 256'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 256'(valid_out), 256'(0));
      chk("arst_vec",   256'(vector_out), 256'(0));
      chk("arst_count", 256'(count_out), 256'(0));
      #1 rst_n = 1'b1;
      // chain 2 firmware back to PASS
      trace(2'd2, 1, 0, seq(55, 1, 8));
      chk("post_valid", 256'(valid_out), 256'(1));
      chk("post_vec",   256'(vector_out), 256'(seq(55, 1, 8)));
      chk("post_count", 256'(count_out), 256'(8));
      trace(2'd2, 0, 1, '0);
      chk("post_eof_valid", 256'(valid_out), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
